// File: rtl/pc_stack_if.sv
// Control strobes and status outputs of the program counter with return-address stack.
// The shared tri-state bus is a plain inout on the module and is not part of this interface.
interface pc_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             load_bar;
  logic             en_bar;
  logic             inc;
  logic             rel_bar;
  logic             call_bar;
  logic             ret_bar;
  logic [WIDTH-1:0] value;
  logic [DW-1:0]    depth;
  logic             overflow;
  logic             underflow;

  modport master (
    output load_bar, en_bar, inc, rel_bar, call_bar, ret_bar,
    input  value, depth, overflow, underflow
  );

  modport slave (
    input  load_bar, en_bar, inc, rel_bar, call_bar, ret_bar,
    output value, depth, overflow, underflow
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with a ring-buffer return stack: load, inc, relative branch, call, ret.
// State and outputs update one posedge after the strobe; the bus drive follows en_bar combinationally.
module pc_stack #(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] bus,
  pc_stack_if.slave        ctl
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [PW-1:0]    sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             push;
  logic [PW-1:0]    sp_inc, sp_dec;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] stk_q [DEPTH];

  // sp_q is the next write slot; when full it also points at the oldest entry.
  assign sp_inc   = (sp_q == PW'(DEPTH - 1)) ? '0 : sp_q + PW'(1);
  assign sp_dec   = (sp_q == '0) ? PW'(DEPTH - 1) : sp_q - PW'(1);
  assign ret_addr = pc_q + WIDTH'(1);

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push    = 1'b0;
    if (!ctl.call_bar) begin
      push = 1'b1;
      pc_d = bus;
      sp_d = sp_inc;
      if (depth_q == DW'(DEPTH)) ovf_d = 1'b1;
      else                       depth_d = depth_q + DW'(1);
    end else if (!ctl.ret_bar) begin
      if (depth_q != '0) begin
        pc_d    = stk_q[sp_dec];
        sp_d    = sp_dec;
        depth_d = depth_q - DW'(1);
      end else begin
        udf_d = 1'b1;
      end
    end else if (!ctl.rel_bar) begin
      pc_d = pc_q + bus;
    end else if (!ctl.load_bar) begin
      pc_d = bus;
    end else if (ctl.inc) begin
      pc_d = ret_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VALUE;
      depth_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Stack storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && !reset) stk_q[sp_q] <= ret_addr;
  end

  assign bus           = ctl.en_bar ? {WIDTH{1'bz}} : pc_q;
  assign ctl.value     = pc_q;
  assign ctl.depth     = depth_q;
  assign ctl.overflow  = ovf_q;
  assign ctl.underflow = udf_q;
endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack (WIDTH=16, DEPTH=4): expectations queued at drive time, checked after the edge.
module tb_pc_stack;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  wire  [15:0] bus;
  logic        drv_en = 1'b0;
  logic [15:0] drv = '0;

  assign bus = drv_en ? drv : 16'bz;

  pc_stack_if #(.WIDTH(16), .DEPTH(4)) pif ();

  pc_stack #(.WIDTH(16), .DEPTH(4), .RESET_VALUE(16'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ctl   (pif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] v;
    logic [2:0]  d;
    logic        o;
    logic        u;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_bad = 0;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] CALL = 5'b10000;
  localparam logic [4:0] RET  = 5'b01000;
  localparam logic [4:0] REL  = 5'b00100;
  localparam logic [4:0] LD   = 5'b00010;
  localparam logic [4:0] INC  = 5'b00001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input logic [15:0] v, input int d, input logic o, input logic u);
    exp_t e;
    e.v = v;
    e.d = 3'(d);
    e.o = o;
    e.u = u;
    sbq.push_back(e);
  endtask

  task automatic compare_state(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".value"}, 32'(pif.value), 32'(e.v));
      chk({tag, ".depth"}, 32'(pif.depth), 32'(e.d));
      chk({tag, ".ovf"},   32'(pif.overflow), 32'(e.o));
      chk({tag, ".udf"},   32'(pif.underflow), 32'(e.u));
    end
  endtask

  task automatic idle();
    pif.call_bar = 1'b1;
    pif.ret_bar  = 1'b1;
    pif.rel_bar  = 1'b1;
    pif.load_bar = 1'b1;
    pif.inc      = 1'b0;
    drv_en       = 1'b0;
  endtask

  task automatic step(input string tag, input logic [4:0] stb, input logic [15:0] b,
                      input logic [15:0] ev, input int ed, input logic eo, input logic eu);
    @(negedge clk);
    pif.call_bar = !stb[4];
    pif.ret_bar  = !stb[3];
    pif.rel_bar  = !stb[2];
    pif.load_bar = !stb[1];
    pif.inc      = stb[0];
    drv          = b;
    drv_en       = 1'b1;
    expect_state(ev, ed, eo, eu);
    @(posedge clk);
    #1;
    compare_state(tag);
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    expect_state(16'd0, 0, 1'b0, 1'b0);
    #1;
    compare_state("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    idle();
    pif.en_bar = 1'b1;
    expect_state(16'd0, 0, 1'b0, 1'b0);
    #2;
    compare_state("por");
    @(negedge clk);
    reset = 1'b0;

    step("ld1500", LD,   16'd1500, 16'd1500, 0, 0, 0);
    step("inc",    INC,  16'd0,    16'd1501, 0, 0, 0);
    step("hold",   NONE, 16'd0,    16'd1501, 0, 0, 0);
    @(negedge clk);
    pif.inc = 1'b1;
    #2;
    pif.inc = 1'b0;
    #1;
    expect_state(16'd1501, 0, 1'b0, 1'b0);
    compare_state("inc_no_edge");

    step("ldmax",  LD,   16'hFFFF, 16'hFFFF, 0, 0, 0);
    step("incwrap",INC,  16'd0,    16'd0,    0, 0, 0);
    step("ld10",   LD,   16'd10,   16'd10,   0, 0, 0);
    step("relneg", REL,  16'hFFFF, 16'd9,    0, 0, 0);
    step("relpos", REL,  16'd5,    16'd14,   0, 0, 0);

    step("ld100",  LD,   16'd100,  16'd100,  0, 0, 0);
    step("call1",  CALL, 16'h2000, 16'h2000, 1, 0, 0);
    step("ret1",   RET,  16'd0,    16'd101,  0, 0, 0);
    step("ret_uf", RET,  16'd0,    16'd101,  0, 0, 1);
    step("uf_stk", INC,  16'd0,    16'd102,  0, 0, 1);

    do_reset();
    step("ld10h",  LD,   16'h10,   16'h10,   0, 0, 0);
    for (int i = 1; i <= 5; i++)
      step("call5", CALL, 16'((i + 1) * 16), 16'((i + 1) * 16), (i > 4) ? 4 : i, i > 4, 1'b0);
    step("ret_a",  RET,  16'd0,    16'h51,   3, 1, 0);
    step("ret_b",  RET,  16'd0,    16'h41,   2, 1, 0);
    step("ret_c",  RET,  16'd0,    16'h31,   1, 1, 0);
    step("ret_d",  RET,  16'd0,    16'h21,   0, 1, 0);
    step("ret_e",  RET,  16'd0,    16'h21,   0, 1, 1);

    do_reset();
    step("ld300",  LD,   16'h300,  16'h300,  0, 0, 0);
    step("call_p", CALL, 16'h400,  16'h400,  1, 0, 0);
    step("prio",   CALL | RET | LD | INC | REL, 16'h500, 16'h500, 2, 0, 0);
    step("prio_r", RET,  16'd0,    16'h401,  1, 0, 0);
    step("ret_rl", RET | REL | LD, 16'h7, 16'h301, 0, 0, 0);
    step("rel_ld", REL | LD | INC, 16'h10, 16'h311, 0, 0, 0);
    step("ld_inc", LD | INC, 16'h42, 16'h42, 0, 0, 0);

    step("ld6502", LD,   16'd6502, 16'd6502, 0, 0, 0);
    @(negedge clk);
    pif.en_bar = 1'b0;
    #1;
    chk("bus_drive", 32'(bus), 32'd6502);
    pif.load_bar = 1'b0;
    expect_state(16'd6502, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    compare_state("ld_self");
    pif.load_bar = 1'b1;
    pif.en_bar   = 1'b1;
    drv          = 16'd2056;
    drv_en       = 1'b1;
    #1;
    chk("bus_ext", 32'(bus), 32'd2056);
    drv_en = 1'b0;

    step("ld0",    LD,   16'd0,    16'd0,    0, 0, 0);
    for (int i = 1; i <= 5; i++)
      step("callm", CALL, 16'(i), 16'(i), (i > 4) ? 4 : i, i > 4, 1'b0);
    step("ret_m",  RET,  16'd0,    16'd5,    3, 1, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    expect_state(16'd0, 0, 1'b0, 1'b0);
    compare_state("midrst");
    @(negedge clk);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
